cache_refill_ctrl: RTL
======================

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameter ADDR_W, default 15, SHALL set the word-address width of request, cache and memory addresses.
REQ-002 Parameter DATA_W, default 32, SHALL set the word width; block size SHALL be fixed at 4 words.
REQ-003 clk  input  1  SHALL be the clock; all state updates on rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 req_valid  input  1  SHALL indicate the CPU-side address is valid this cycle.
REQ-006 req_addr  input  ADDR_W  SHALL be the CPU word address.
REQ-007 cache_miss  input  1  SHALL be the cache's combinational miss flag for req_addr.
REQ-008 stall  output  1  SHALL hold the requester while a refill is in progress.
REQ-009 mem_rd  output  1  SHALL request one word from main memory.
REQ-010 mem_addr  output  ADDR_W  SHALL be the word address of the current memory read.
REQ-011 mem_rdata  input  DATA_W  SHALL be the memory read data.
REQ-012 mem_rvalid  input  1  SHALL mark mem_rdata valid for the current mem_rd.
REQ-013 cache_addr  output  ADDR_W  SHALL be the address presented to the cache during the write.
REQ-014 block_data  output  4*DATA_W  SHALL carry words 0..3; word i in bits [i*DATA_W +: DATA_W].
REQ-015 cache_write  output  1  SHALL be the one-cycle cache block-write strobe.
REQ-016 refill_done  output  1  SHALL be a one-cycle pulse when a refill completes.
REQ-017 miss_count, hit_count  output  16 each  SHALL be statistics counters (see Configuration).

Function
REQ-018 FSM states SHALL be IDLE, FETCH, WRITE, DONE; encoding is free.
REQ-019 IDLE: when req_valid=1 and cache_miss=1 at a clock edge, the block SHALL latch req_addr, set base = {req_addr[ADDR_W-1:2],2'b00}, clear word index to 0 and enter FETCH.
REQ-020 stall SHALL be 1 in FETCH and WRITE, and 0 in IDLE and DONE.
REQ-021 FETCH: mem_rd SHALL be 1, with mem_addr = base + index; only one read SHALL be outstanding.
REQ-022 FETCH: on an edge with mem_rvalid=1, mem_rdata SHALL be stored into buffer word[index]. If index=3, the FSM SHALL enter WRITE; otherwise index SHALL increment.
REQ-023 FETCH: while mem_rvalid=0, the FSM SHALL hold mem_rd, mem_addr and index unchanged; the wait is unbounded.
REQ-024 mem_rvalid outside FETCH SHALL be ignored.
REQ-025 WRITE: cache_write SHALL be 1 for exactly one cycle, cache_addr SHALL be the latched req_addr, and block_data SHALL be the 4 buffered words; the FSM SHALL then enter DONE.
REQ-026 DONE: refill_done SHALL be 1 for one cycle; the FSM SHALL then enter IDLE, which SHALL NOT start a new refill in that same transition.
REQ-027 cache_addr SHALL equal req_addr in IDLE and DONE, and SHALL equal the latched address in FETCH and WRITE.
REQ-028 block_data SHALL hold its last value outside WRITE.
REQ-029 Latency with zero-wait memory (mem_rvalid=1 whenever mem_rd=1): miss detected at edge N; FETCH cycles N+1..N+4; WRITE N+5; DONE N+6; IDLE N+7.
REQ-030 base+index SHALL NOT carry out of bits [1:0], so the block SHALL never cross a 4-word boundary.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, index=0, buffers=0, latched address=0, counters=0, and stall, mem_rd, cache_write, refill_done=0.
REQ-032 Reset during FETCH or WRITE SHALL abandon the refill with no cache_write; after release, a still-pending miss SHALL start a fresh refill from word 0.

Configuration
REQ-033 With macro REFILL_STATS_EN defined:
- miss_count SHALL increment on each IDLE->FETCH transition.
- hit_count SHALL increment on each IDLE edge with req_valid=1 and cache_miss=0.
- Both counters SHALL saturate at 16'hFFFF.
REQ-034 Without REFILL_STATS_EN, both ports SHALL remain present and SHALL be tied to 0, with no counter logic.

Verification
REQ-035 Zero-wait memory, req_addr=15'h1235 with a miss -> mem_addr sequence 1234,1235,1236,1237; cache_write at N+5 with cache_addr=1235; refill_done at N+6.
REQ-036 mem_rvalid delayed 3 cycles per word, data = address+32'hA000 -> block_data = {A007,A006,A005,A004}, reading words 3..0, for req_addr 15'h0006.
REQ-037 rst pulsed during FETCH after 2 words -> no cache_write; after release with a held miss, refill restarts at mem_addr=base.
REQ-038 req_addr=15'h7FFF miss -> mem_addr 7FFC..7FFF; no wrap into a 0000 access.
REQ-039 REFILL_STATS_EN: 3 hits and 2 misses -> hit_count=3, miss_count=2; with the macro undefined, both counters read 0.
REQ-040 Stray mem_rvalid=1 in IDLE with cache_miss=0 -> no state change, no buffer update, stall=0.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: fetches a 4-word block from main memory on a cache miss,
// one outstanding word read at a time, then writes the whole block to the cache.
// Optional statistics counters are compiled in when REFILL_STATS_EN is defined;
// otherwise miss_count and hit_count are tied to zero.
module cache_refill_ctrl #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                cache_miss,
  output logic                stall,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rvalid,
  output logic [ADDR_W-1:0]   cache_addr,
  output logic [4*DATA_W-1:0] block_data,
  output logic                cache_write,
  output logic                refill_done,
  output logic [15:0]         miss_count,
  output logic [15:0]         hit_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [1:0]          index_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   word_q [4];
  logic [4*DATA_W-1:0] word_flat;
  logic [4*DATA_W-1:0] block_q;
  logic                start_refill;

  assign start_refill = (state_q == IDLE) && req_valid && cache_miss;

  // Pack the refill buffer into the block_data bit layout (word i at i*DATA_W).
  always_comb begin
    word_flat = '0;
    for (int i = 0; i < 4; i++) begin
      word_flat[i*DATA_W +: DATA_W] = word_q[i];
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: one word per accepted mem_rvalid, wait unbounded.
  // NOTE: state_d gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_refill) state_d = FETCH;
      FETCH:   if (mem_rvalid && (index_q == 2'd3)) state_d = WRITE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers: latched address, word index, refill buffer, held block.
  // NOTE: the 4-word buffer is a handful of flops, not a RAM, and it must read
  // as zero after reset, so it is reset along with the rest of the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_q <= 2'd0;
      addr_q  <= '0;
      block_q <= '0;
      for (int i = 0; i < 4; i++) word_q[i] <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_refill) begin
            addr_q  <= req_addr;
            index_q <= 2'd0;
          end
        end
        FETCH: begin
          if (mem_rvalid) begin
            word_q[index_q] <= mem_rdata;
            if (index_q != 2'd3) index_q <= index_q + 2'd1;
          end
        end
        WRITE:   block_q <= word_flat;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; the word index replaces the low address bits
  // so a block never carries across its 4-word boundary.
  always_comb begin
    stall       = (state_q == FETCH) || (state_q == WRITE);
    mem_rd      = (state_q == FETCH);
    cache_write = (state_q == WRITE);
    refill_done = (state_q == DONE);
    mem_addr    = {addr_q[ADDR_W-1:2], index_q};
    cache_addr  = stall ? addr_q : req_addr;
    block_data  = (state_q == WRITE) ? word_flat : block_q;
  end

`ifdef REFILL_STATS_EN
  logic [15:0] miss_q;
  logic [15:0] hit_q;

  // Saturating hit/miss statistics, counted only on IDLE-state requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_q <= '0;
      hit_q  <= '0;
    end else if ((state_q == IDLE) && req_valid) begin
      if (cache_miss) begin
        if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
      end else begin
        if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
      end
    end
  end

  assign miss_count = miss_q;
  assign hit_count  = hit_q;
`else
  assign miss_count = 16'd0;
  assign hit_count  = 16'd0;
`endif

endmodule
